processor_sequencer: RTL and testbench

//  Fetch/decode/execute control FSM for the 8-bit processor datapath. Owns the program

---
 rtl/processor_sequencer.sv | 172 +++++++++++++++++
 tb/tb_processor_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/processor_sequencer.sv
// processor_sequencer: fetch/decode/execute/write-back control FSM for the
// 8-bit processor datapath. Owns PC and IR, drives the register latch strobes,
// ALU select/strobe and W-bus source. One micro-step per advance (step | run).
module processor_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       run,
    input  logic [7:0] instr,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic [3:0] alu_sel,
    output logic       alu_latch,
    output logic [2:0] bus_sel,
    output logic       latch_a,
    output logic       latch_b,
    output logic       latch_o,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        BUS_NONE  = 3'd0,
        BUS_ALU   = 3'd1,
        BUS_SW_A  = 3'd2,
        BUS_SW_B  = 3'd3,
        BUS_REG_A = 3'd4,
        BUS_REG_B = 3'd5
    } bus_src_t;

    state_t     state_q,     state_d;
    logic [7:0] pc_q,        pc_d;
    logic [7:0] ir_q,        ir_d;
    logic [3:0] alu_sel_q,   alu_sel_d;
    bus_src_t   bus_sel_q,   bus_sel_d;
    logic       alu_latch_q, alu_latch_d;
    logic       latch_a_q,   latch_a_d;
    logic       latch_b_q,   latch_b_d;
    logic       latch_o_q,   latch_o_d;
    logic       halted_q,    halted_d;

    logic       adv;
    logic [3:0] op;
    logic [1:0] dest;

    assign adv  = step | run;
    assign op   = ir_q[7:4];
    assign dest = ir_q[3:2];

    // State register and all registered outputs; reset overrides any advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            alu_sel_q   <= '0;
            bus_sel_q   <= BUS_NONE;
            alu_latch_q <= 1'b0;
            latch_a_q   <= 1'b0;
            latch_b_q   <= 1'b0;
            latch_o_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_sel_q   <= alu_sel_d;
            bus_sel_q   <= bus_sel_d;
            alu_latch_q <= alu_latch_d;
            latch_a_q   <= latch_a_d;
            latch_b_q   <= latch_b_d;
            latch_o_q   <= latch_o_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state and output decode; strobes default low so each lasts one clock.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        alu_sel_d   = alu_sel_q;
        bus_sel_d   = bus_sel_q;
        alu_latch_d = 1'b0;
        latch_a_d   = 1'b0;
        latch_b_d   = 1'b0;
        latch_o_d   = 1'b0;
        halted_d    = halted_q;

        case (state_q)
            FETCH: begin
                if (adv) begin
                    ir_d    = instr;
                    pc_d    = pc_q + 8'd1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (adv) begin
                    if (op == HALT_OPCODE) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else if (op <= 4'hB) begin
                        state_d = EXEC;
                        // Bus ops drive the W-bus from EXEC entry through WB.
                        case (op)
                            4'h8:    bus_sel_d = BUS_ALU;
                            4'h9:    bus_sel_d = BUS_SW_A;
                            4'hA:    bus_sel_d = BUS_SW_B;
                            4'hB:    bus_sel_d = (dest == 2'b00) ? BUS_REG_A : BUS_REG_B;
                            default: bus_sel_d = bus_sel_q;
                        endcase
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            EXEC: begin
                if (adv) begin
                    if (!op[3]) begin
                        alu_sel_d   = op;
                        alu_latch_d = 1'b1;
                        state_d     = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                if (adv) begin
                    if (op == 4'hB) begin
                        latch_o_d = 1'b1;
                    end else begin
                        latch_a_d = (dest == 2'b00);
                        latch_b_d = (dest == 2'b01);
                    end
                    bus_sel_d = BUS_NONE;
                    state_d   = FETCH;
                end
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign alu_sel   = alu_sel_q;
    assign alu_latch = alu_latch_q;
    assign bus_sel   = bus_sel_q;
    assign latch_a   = latch_a_q;
    assign latch_b   = latch_b_q;
    assign latch_o   = latch_o_q;
    assign halted    = halted_q;
    assign state     = state_q;

endmodule

// File: tb/tb_processor_sequencer.sv
// tb_processor_sequencer: directed steps for processor_sequencer; expected
// snapshots are queued as each clock's stimulus is driven and checked after it.
module tb_processor_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       step;
    logic       run;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [3:0] alu_sel;
    logic       alu_latch;
    logic [2:0] bus_sel;
    logic       latch_a;
    logic       latch_b;
    logic       latch_o;
    logic       halted;
    logic [2:0] state;

    processor_sequencer #(
        .RESET_PC    (8'h00),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .run       (run),
        .instr     (instr),
        .pc        (pc),
        .ir        (ir),
        .alu_sel   (alu_sel),
        .alu_latch (alu_latch),
        .bus_sel   (bus_sel),
        .latch_a   (latch_a),
        .latch_b   (latch_b),
        .latch_o   (latch_o),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    // stb = {alu_latch, latch_a, latch_b, latch_o}
    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ir;
        logic [3:0] alu;
        logic [2:0] bus;
        logic [3:0] stb;
        logic       halt;
        logic [2:0] st;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic cmp(input string tag, input string fld,
                       input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, got, exp);
        end
    endtask

    // One clock: queue expectation, apply step/reset, compare #1 after the edge.
    task automatic cyc(input string tag, input logic s, input logic r, input exp_t e);
        exp_t  x;
        string t;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        step  = s;
        reset = r;
        @(posedge clk);
        #1;
        step  = 1'b0;
        reset = 1'b0;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            x = sb_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, "pc",    pc,                                  x.pc);
            cmp(t, "ir",    ir,                                  x.ir);
            cmp(t, "alu",   {4'h0, alu_sel},                     {4'h0, x.alu});
            cmp(t, "bus",   {5'h0, bus_sel},                     {5'h0, x.bus});
            cmp(t, "stb",   {4'h0, alu_latch, latch_a, latch_b, latch_o}, {4'h0, x.stb});
            cmp(t, "halt",  {7'h0, halted},                      {7'h0, x.halt});
            cmp(t, "state", {5'h0, state},                       {5'h0, x.st});
        end
    endtask

    function automatic exp_t mk(input logic [7:0] p, input logic [7:0] i,
                                input logic [3:0] a, input logic [2:0] b,
                                input logic [3:0] s, input logic h, input logic [2:0] st);
        exp_t e;
        e.pc = p; e.ir = i; e.alu = a; e.bus = b; e.stb = s; e.halt = h; e.st = st;
        return e;
    endfunction

    initial begin
        reset = 1'b1;
        step  = 1'b0;
        run   = 1'b0;
        instr = 8'h90;
        @(posedge clk);
        #1;

        // T1: load sw_a -> A
        cyc("t1_rst",   1'b0, 1'b1, mk(8'h00, 8'h00, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));
        cyc("t1_idle",  1'b0, 1'b0, mk(8'h00, 8'h00, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));
        cyc("t1_fetch", 1'b1, 1'b0, mk(8'h01, 8'h90, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t1_dec",   1'b1, 1'b0, mk(8'h01, 8'h90, 4'h0, 3'd2, 4'b0000, 1'b0, 3'd2));
        cyc("t1_exec",  1'b1, 1'b0, mk(8'h01, 8'h90, 4'h0, 3'd2, 4'b0000, 1'b0, 3'd3));
        cyc("t1_wb",    1'b1, 1'b0, mk(8'h01, 8'h90, 4'h0, 3'd0, 4'b0100, 1'b0, 3'd0));
        cyc("t1_after", 1'b0, 1'b0, mk(8'h01, 8'h90, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));

        // T2: ALU op 2
        instr = 8'h20;
        cyc("t2_fetch", 1'b1, 1'b0, mk(8'h02, 8'h20, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t2_dec",   1'b1, 1'b0, mk(8'h02, 8'h20, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd2));
        cyc("t2_exec",  1'b1, 1'b0, mk(8'h02, 8'h20, 4'h2, 3'd0, 4'b1000, 1'b0, 3'd0));
        cyc("t2_after", 1'b0, 1'b0, mk(8'h02, 8'h20, 4'h2, 3'd0, 4'b0000, 1'b0, 3'd0));

        // T3: HALT, advances ignored, reset exits
        instr = 8'hF0;
        cyc("t3_fetch", 1'b1, 1'b0, mk(8'h03, 8'hF0, 4'h2, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t3_dec",   1'b1, 1'b0, mk(8'h03, 8'hF0, 4'h2, 3'd0, 4'b0000, 1'b1, 3'd4));
        for (int i = 0; i < 5; i++)
            cyc("t3_hold", 1'b1, 1'b0, mk(8'h03, 8'hF0, 4'h2, 3'd0, 4'b0000, 1'b1, 3'd4));
        cyc("t3_rst",   1'b0, 1'b1, mk(8'h00, 8'h00, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));

        // T4: free-run NOP stream, 2 clocks per instruction, pc wraps FF -> 00
        instr = 8'hC0;
        run   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cyc("t4_fetch", 1'b0, 1'b0,
                mk(8'((i + 1) % 256), 8'hC0, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
            cyc("t4_dec", 1'b0, 1'b0,
                mk(8'((i + 1) % 256), 8'hC0, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));
        end
        run = 1'b0;
        cyc("t4_stop",  1'b0, 1'b0, mk(8'h00, 8'hC0, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));

        // T5: reset together with the WB advance suppresses latch_b
        instr = 8'h94;
        cyc("t5_fetch", 1'b1, 1'b0, mk(8'h01, 8'h94, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t5_dec",   1'b1, 1'b0, mk(8'h01, 8'h94, 4'h0, 3'd2, 4'b0000, 1'b0, 3'd2));
        cyc("t5_exec",  1'b1, 1'b0, mk(8'h01, 8'h94, 4'h0, 3'd2, 4'b0000, 1'b0, 3'd3));
        cyc("t5_rstwb", 1'b1, 1'b1, mk(8'h00, 8'h00, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));
        cyc("t5_after", 1'b0, 1'b0, mk(8'h00, 8'h00, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));

        // T6: dest 1x gives no strobe; op B with dest 01 sources reg_b into OUT
        instr = 8'h98;
        cyc("t6a_fetch", 1'b1, 1'b0, mk(8'h01, 8'h98, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t6a_dec",   1'b1, 1'b0, mk(8'h01, 8'h98, 4'h0, 3'd2, 4'b0000, 1'b0, 3'd2));
        cyc("t6a_exec",  1'b1, 1'b0, mk(8'h01, 8'h98, 4'h0, 3'd2, 4'b0000, 1'b0, 3'd3));
        cyc("t6a_wb",    1'b1, 1'b0, mk(8'h01, 8'h98, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));
        instr = 8'hB4;
        cyc("t6b_fetch", 1'b1, 1'b0, mk(8'h02, 8'hB4, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t6b_dec",   1'b1, 1'b0, mk(8'h02, 8'hB4, 4'h0, 3'd5, 4'b0000, 1'b0, 3'd2));
        cyc("t6b_exec",  1'b1, 1'b0, mk(8'h02, 8'hB4, 4'h0, 3'd5, 4'b0000, 1'b0, 3'd3));
        cyc("t6b_wb",    1'b1, 1'b0, mk(8'h02, 8'hB4, 4'h0, 3'd0, 4'b0001, 1'b0, 3'd0));
        cyc("t6b_after", 1'b0, 1'b0, mk(8'h02, 8'hB4, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd0));

        // step held high across clocks acts as consecutive advances
        instr = 8'h31;
        step  = 1'b1;
        cyc("t7_fetch", 1'b1, 1'b0, mk(8'h03, 8'h31, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd1));
        cyc("t7_dec",   1'b1, 1'b0, mk(8'h03, 8'h31, 4'h0, 3'd0, 4'b0000, 1'b0, 3'd2));
        cyc("t7_exec",  1'b1, 1'b0, mk(8'h03, 8'h31, 4'h3, 3'd0, 4'b1000, 1'b0, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
